// File: rtl/muldiv_pkg.sv
// Shared types for the iterative multiply/divide unit.
// Op encoding, FSM states and per-op signedness helpers.
package muldiv_pkg;

   localparam int MULDIV_WIDTH = 32;

   typedef enum logic [2:0] {
      OP_MUL    = 3'd0,
      OP_MULH   = 3'd1,
      OP_MULHSU = 3'd2,
      OP_MULHU  = 3'd3,
      OP_DIV    = 3'd4,
      OP_DIVU   = 3'd5,
      OP_REM    = 3'd6,
      OP_REMU   = 3'd7
   } muldiv_op_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } muldiv_state_t;

   function automatic logic op_is_div(muldiv_op_t o);
      return o inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
   endfunction

   function automatic logic op_a_signed(muldiv_op_t o);
      return o inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
   endfunction

   function automatic logic op_b_signed(muldiv_op_t o);
      return o inside {OP_MULH, OP_DIV, OP_REM};
   endfunction

endpackage

// File: rtl/muldiv_special.sv
// Early-out detection for divide-by-zero and signed overflow.
// Produces the architectural result without iterating.
module muldiv_special
   import muldiv_pkg::*;
#(
   parameter int WIDTH = MULDIV_WIDTH
) (
   input  muldiv_op_t       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             hit,
   output logic [WIDTH-1:0] res
);

   localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};

   logic is_rem;
   logic dz;
   logic ovf;

   always_comb begin
      is_rem = op inside {OP_REM, OP_REMU};
      dz     = op_is_div(op) && (b == '0);
      ovf    = op_is_div(op) && op_b_signed(op)
               && (a == MINV) && (b == '1);
      hit    = dz | ovf;
      res    = '0;
      unique case (1'b1)
         dz:      res = is_rem ? a : '1;
         ovf:     res = is_rem ? '0 : a;
         default: res = '0;
      endcase
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative M-extension unit: shift-add multiply and restoring
// divide on magnitudes, one bit per cycle, sign fixed at the end.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH = MULDIV_WIDTH,
   parameter int CNT_W = $clog2(WIDTH+1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  muldiv_op_t       op,
   input  logic [WIDTH-1:0] SrcA,
   input  logic [WIDTH-1:0] SrcB,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             busy
);

   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);

   muldiv_state_t    state, state_nx;
   muldiv_op_t       op_q;
   logic [WIDTH-1:0] a_q, b_q, dv_q, hi_q, lo_q, res_q;
   logic [CNT_W-1:0] cnt_q;
   logic             neg_q, rneg_q;

   logic             accept, first;
   logic             a_neg, b_neg;
   logic [WIDTH-1:0] a_mag, b_mag;
   logic [WIDTH:0]   mul_sum, div_sh, div_df;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0] quo, rem, fix_res;
   logic             sp_hit;
   logic [WIDTH-1:0] sp_res;

   muldiv_special #(.WIDTH(WIDTH)) u_special (
      .op  (op_q),
      .a   (a_q),
      .b   (b_q),
      .hit (sp_hit),
      .res (sp_res)
   );

   assign accept = in_valid & in_ready & ~flush;
   assign first  = (cnt_q == CNT_INIT);
   assign result = res_q;

   always_comb begin
      a_neg   = op_a_signed(op) & SrcA[WIDTH-1];
      b_neg   = op_b_signed(op) & SrcB[WIDTH-1];
      a_mag   = a_neg ? -SrcA : SrcA;
      b_mag   = b_neg ? -SrcB : SrcB;
      mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, dv_q} : '0);
      div_sh  = {hi_q, lo_q[WIDTH-1]};
      div_df  = div_sh - {1'b0, dv_q};
      prod    = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
      quo     = neg_q ? -lo_q : lo_q;
      rem     = rneg_q ? -hi_q : hi_q;
      fix_res = '0;
      unique case (op_q)
         OP_MUL:                       fix_res = prod[WIDTH-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod[2*WIDTH-1:WIDTH];
         OP_DIV, OP_DIVU:              fix_res = quo;
         OP_REM, OP_REMU:              fix_res = rem;
         default:                      fix_res = '0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         ST_IDLE: if (accept) state_nx = ST_CALC;
         ST_CALC: begin
            if (first && sp_hit)    state_nx = ST_DONE;
            else if (cnt_q == '0)   state_nx = ST_FIX;
         end
         ST_FIX:  state_nx = ST_DONE;
         ST_DONE: if (out_ready) state_nx = ST_IDLE;
         default: state_nx = ST_IDLE;
      endcase
      if (flush) state_nx = ST_IDLE;
   end

   always_comb begin
      in_ready  = 1'b0;
      busy      = 1'b1;
      out_valid = 1'b0;
      unique case (state)
         ST_IDLE: begin
            in_ready = ~rst;
            busy     = 1'b0;
         end
         ST_DONE: out_valid = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q   <= OP_MUL;
         a_q    <= '0;
         b_q    <= '0;
         dv_q   <= '0;
         hi_q   <= '0;
         lo_q   <= '0;
         res_q  <= '0;
         cnt_q  <= '0;
         neg_q  <= 1'b0;
         rneg_q <= 1'b0;
      end else if (accept) begin
         op_q   <= op;
         a_q    <= SrcA;
         b_q    <= SrcB;
         hi_q   <= '0;
         cnt_q  <= CNT_INIT;
         neg_q  <= a_neg ^ b_neg;
         rneg_q <= a_neg;
         // divisor and multiplicand share dv_q
         dv_q   <= op_is_div(op) ? b_mag : a_mag;
         lo_q   <= op_is_div(op) ? a_mag : b_mag;
      end else if (state == ST_CALC) begin
         if (first && sp_hit) res_q <= sp_res;
         if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
            if (op_is_div(op_q)) begin
               hi_q <= div_df[WIDTH] ? div_sh[WIDTH-1:0]
                                     : div_df[WIDTH-1:0];
               lo_q <= {lo_q[WIDTH-2:0], ~div_df[WIDTH]};
            end else begin
               {hi_q, lo_q} <= {mul_sum, lo_q[WIDTH-1:1]};
            end
         end
      end else if (state == ST_FIX) begin
         res_q <= fix_res;
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases,
// flush/reset aborts and random ops against an arithmetic model.
module tb_muldiv_unit;
   import muldiv_pkg::*;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   muldiv_op_t    op;
   logic [W-1:0]  SrcA;
   logic [W-1:0]  SrcB;
   logic          flush;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  result;
   logic          busy;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   muldiv_unit #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .SrcA      (SrcA),
      .SrcB      (SrcB),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .busy      (busy)
   );

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model(input logic [2:0] o,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
      logic signed [63:0] sa, sb, ub;
      logic [63:0] p;
      int ia, ib;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      ub = {32'b0, b};
      ia = a;
      ib = b;
      case (o)
         3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * ub; return p[63:32]; end
         3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
            return ia / ib;
         end
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
            return ia % ib;
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic int lat_model(input logic [2:0] o,
                                    input logic [31:0] a,
                                    input logic [31:0] b);
      if (o >= 3'd4 && b == 0) return 1;
      if ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000
          && b == 32'hFFFF_FFFF) return 1;
      return W + 2;
   endfunction

   task automatic start(input string tag, input logic [2:0] o,
                        input logic [31:0] a, input logic [31:0] b);
      int n;
      n = 0;
      while (in_ready !== 1'b1 && n < 200) begin
         @(posedge clk); #1; n++;
      end
      chk({tag, " ready"}, 64'(in_ready), 64'd1);
      op = muldiv_op_t'(o);
      SrcA = a;
      SrcB = b;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      op = muldiv_op_t'(3'($urandom));
      SrcA = $urandom;
      SrcB = $urandom;
   endtask

   task automatic run_op(input string tag, input logic [2:0] o,
                         input logic [31:0] a, input logic [31:0] b,
                         input int hold);
      logic [31:0] er;
      int el, n;
      er = model(o, a, b);
      el = lat_model(o, a, b);
      start(tag, o, a, b);
      n = 0;
      do begin
         @(posedge clk); #1; n++;
      end while (out_valid !== 1'b1 && n < 100);
      chk({tag, " latency"}, 64'(n), 64'(el));
      chk({tag, " result"}, 64'(result), 64'(er));
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         chk({tag, " hold valid"}, 64'(out_valid), 64'd1);
         chk({tag, " hold result"}, 64'(result), 64'(er));
         chk({tag, " hold in_ready"}, 64'(in_ready), 64'd0);
      end
      out_ready = 1'b1;
      chk({tag, " in_ready at hs"}, 64'(in_ready), 64'd0);
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({tag, " valid after hs"}, 64'(out_valid), 64'd0);
      chk({tag, " in_ready after hs"}, 64'(in_ready), 64'd1);
   endtask

   task automatic no_pulse(input string tag, input int cycles);
      int pulses;
      pulses = 0;
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk); #1;
         if (out_valid !== 1'b0) pulses++;
      end
      chk({tag, " no pulse"}, 64'(pulses), 64'd0);
   endtask

   initial begin
      logic [2:0]  ro;
      logic [31:0] ra, rb;
      int          rk;

      rst = 1'b1;
      in_valid = 1'b0;
      flush = 1'b0;
      out_ready = 1'b0;
      op = OP_MUL;
      SrcA = '0;
      SrcB = '0;
      #12;
      chk("rst out_valid", 64'(out_valid), 64'd0);
      chk("rst result", 64'(result), 64'd0);
      chk("rst busy", 64'(busy), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("post rst in_ready", 64'(in_ready), 64'd1);

      run_op("mul", 3'd0, 32'd7, 32'hFFFF_FFFD, 0);
      chk("mul const", 64'(result), 64'hFFFF_FFEB);
      run_op("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
      run_op("mulh", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'd2, 0);
      run_op("div", 3'd4, 32'hFFFF_FFF9, 32'd2, 0);
      run_op("rem", 3'd6, 32'hFFFF_FFF9, 32'd2, 0);
      run_op("divu", 3'd5, 32'd100, 32'd7, 0);
      run_op("remu", 3'd7, 32'd100, 32'd7, 0);
      run_op("divu0", 3'd5, 32'd5, 32'd0, 0);
      run_op("rem0", 3'd6, 32'd5, 32'd0, 0);
      run_op("divovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      run_op("removf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      run_op("hold10", 3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 10);

      start("flush", 3'd0, 32'h0000_1234, 32'h0000_5678);
      for (int i = 1; i < 5; i++) begin
         @(posedge clk); #1;
      end
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      chk("flush busy", 64'(busy), 64'd0);
      chk("flush in_ready", 64'(in_ready), 64'd1);
      no_pulse("flush", 40);

      start("reset", 3'd4, 32'hDEAD_BEEF, 32'd13);
      for (int i = 1; i < 12; i++) begin
         @(posedge clk); #1;
      end
      #2;
      rst = 1'b1;
      #1;
      chk("midrst valid", 64'(out_valid), 64'd0);
      chk("midrst busy", 64'(busy), 64'd0);
      chk("midrst result", 64'(result), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("midrst in_ready", 64'(in_ready), 64'd1);
      no_pulse("reset", 40);
      run_op("after abort", 3'd5, 32'hDEAD_BEEF, 32'd13, 0);

      for (int i = 0; i < 24; i++) begin
         ro = 3'($urandom_range(0, 7));
         ra = $urandom;
         rb = $urandom;
         rk = $urandom_range(0, 9);
         if (rk == 0) rb = 32'd0;
         if (rk == 1) begin
            ra = 32'h8000_0000;
            rb = 32'hFFFF_FFFF;
         end
         if (rk == 2) rb = 32'($urandom_range(1, 15));
         if (rk == 3) rb = -32'($urandom_range(1, 15));
         run_op("rand", ro, ra, rb, $urandom_range(0, 3));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
